// File: rtl/key_debounce_multi.sv
// key_debounce_multi
//   N-channel key conditioner. Each channel has a 2-flop synchroniser,
//   polarity normalisation, a debounce/hold counter, a release counter
//   and a small FSM. It produces a clean level plus single-cycle
//   press / release / short-click / long-press pulses.
//
//   Optional build macro KEY_REPEAT_EN: while a key stays in LONG,
//   key_press auto-repeats every REPEAT_CYCLES cycles.
//
// Ports
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   i_key_in      raw key pins, asynchronous to clk
//   o_key_level   debounced level, 1 = pressed
//   o_key_press   1-cycle pulse on accepted press (and on auto-repeat)
//   o_key_release 1-cycle pulse on accepted release
//   o_key_short   1-cycle pulse on release of a press that never went long
//   o_key_long    1-cycle pulse once per press after LONG_CYCLES held
//
// FSM states (per channel)
//   state        | meaning
//   ST_IDLE      | key released, waiting for a pressed sample
//   ST_PRESSING  | counting stable pressed samples
//   ST_HELD      | press accepted, hold counter running toward long
//   ST_LONG      | long-press fired (repeat timer runs here if enabled)
//   ST_RELEASING | counting stable released samples from HELD or LONG
module key_debounce_multi #(
  parameter int KEY_NUM         = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_NUM-1:0] i_key_in,
  output logic [KEY_NUM-1:0] o_key_level,
  output logic [KEY_NUM-1:0] o_key_press,
  output logic [KEY_NUM-1:0] o_key_release,
  output logic [KEY_NUM-1:0] o_key_short,
  output logic [KEY_NUM-1:0] o_key_long
);

  localparam int MAX_A  = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
  localparam int MAX_C  = (MAX_A > REPEAT_CYCLES) ? MAX_A : REPEAT_CYCLES;
  localparam int CW     = $clog2(MAX_C) + 1;
  // Pin value seen while the key is released.
  localparam logic REL_LVL = (ACTIVE_LOW != 0);

  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
`ifdef KEY_REPEAT_EN
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
`endif

  generate
    if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
      $error("key_debounce_multi: LONG_CYCLES must exceed DEBOUNCE_CYCLES");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb
      $error("key_debounce_multi: DEBOUNCE_CYCLES must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESSING,
    ST_HELD,
    ST_LONG,
    ST_RELEASING
  } state_t;

  for (genvar g = 0; g < KEY_NUM; g++) begin : g_ch
    logic [1:0]    r_sync;
    logic          w_s;
    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [CW-1:0] r_rc, w_rc_nxt;
    logic          r_long_seen, w_long_seen_nxt;
    logic          r_level, w_level_nxt;
    logic          r_press, w_press;
    logic          r_release, w_release;
    logic          r_short, w_short;
    logic          r_long, w_long;

    assign w_s = r_sync[1] ^ REL_LVL;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sync      <= {2{REL_LVL}};
        r_state     <= ST_IDLE;
        r_cnt       <= '0;
        r_rc        <= '0;
        r_long_seen <= 1'b0;
        r_level     <= 1'b0;
        r_press     <= 1'b0;
        r_release   <= 1'b0;
        r_short     <= 1'b0;
        r_long      <= 1'b0;
      end else begin
        r_sync      <= {r_sync[0], i_key_in[g]};
        r_state     <= w_state_nxt;
        r_cnt       <= w_cnt_nxt;
        r_rc        <= w_rc_nxt;
        r_long_seen <= w_long_seen_nxt;
        r_level     <= w_level_nxt;
        r_press     <= w_press;
        r_release   <= w_release;
        r_short     <= w_short;
        r_long      <= w_long;
      end
    end

    always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_rc_nxt        = r_rc;
      w_long_seen_nxt = r_long_seen;
      w_level_nxt     = r_level;
      w_press         = 1'b0;
      w_release       = 1'b0;
      w_short         = 1'b0;
      w_long          = 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_s) begin
            w_state_nxt = ST_PRESSING;
            w_cnt_nxt   = CW'(1);
          end
        end
        ST_PRESSING: begin
          if (!w_s) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == DEB_LAST) begin
            w_state_nxt     = ST_HELD;
            w_cnt_nxt       = '0;
            w_press         = 1'b1;
            w_level_nxt     = 1'b1;
            w_long_seen_nxt = 1'b0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        ST_HELD: begin
          w_cnt_nxt = r_cnt + CW'(1);
          if (r_cnt == LONG_LAST) begin
            w_state_nxt     = ST_LONG;
            w_cnt_nxt       = '0;
            w_long          = 1'b1;
            w_long_seen_nxt = 1'b1;
          end
          // A release start overrides the HELD/LONG target; the origin is
          // remembered in r_long_seen.
          if (!w_s) begin
            w_state_nxt = ST_RELEASING;
            w_rc_nxt    = CW'(1);
          end
        end
        ST_LONG: begin
          if (!w_s) begin
            w_state_nxt = ST_RELEASING;
            w_rc_nxt    = CW'(1);
          end
`ifdef KEY_REPEAT_EN
          else if (r_cnt == REP_LAST) begin
            w_press   = 1'b1;
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
`endif
        end
        ST_RELEASING: begin
          // Hold timer keeps running during a release count from HELD;
          // the repeat timer (LONG origin) is paused.
          if (!r_long_seen) begin
            if (r_cnt == LONG_LAST) begin
              w_long          = 1'b1;
              w_long_seen_nxt = 1'b1;
              w_cnt_nxt       = '0;
            end else begin
              w_cnt_nxt = r_cnt + CW'(1);
            end
          end
          if (w_s) begin
            w_rc_nxt = '0;
            if (w_long_seen_nxt) begin
              w_state_nxt = ST_LONG;
              w_cnt_nxt   = '0;
            end else begin
              w_state_nxt = ST_HELD;
            end
          end else if (r_rc == DEB_LAST) begin
            w_state_nxt     = ST_IDLE;
            w_cnt_nxt       = '0;
            w_rc_nxt        = '0;
            w_long_seen_nxt = 1'b0;
            w_level_nxt     = 1'b0;
            w_release       = 1'b1;
            w_short         = !(r_long_seen || w_long);
          end else begin
            w_rc_nxt = r_rc + CW'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_rc_nxt    = '0;
        end
      endcase
    end

    assign o_key_level[g]   = r_level;
    assign o_key_press[g]   = r_press;
    assign o_key_release[g] = r_release;
    assign o_key_short[g]   = r_short;
    assign o_key_long[g]    = r_long;
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
module tb_key_debounce_multi;

  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] key_in;
  logic [N-1:0] key_level, key_press, key_release, key_short, key_long;

  key_debounce_multi #(
    .KEY_NUM(N),
    .DEBOUNCE_CYCLES(8),
    .LONG_CYCLES(40),
    .REPEAT_CYCLES(10),
    .ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_key_in(key_in),
    .o_key_level(key_level),
    .o_key_press(key_press),
    .o_key_release(key_release),
    .o_key_short(key_short),
    .o_key_long(key_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // Event monitor, sampled on the falling edge.
  int press_cnt[N], release_cnt[N], short_cnt[N], long_cnt[N], level_hi[N];
  int press_first[N], release_cyc[N], short_cyc[N], long_cyc[N];
  int all_press_cnt, all_press_cyc, overlap_cnt;
  logic [N-1:0] rel_mask;

  task automatic clear_mon();
    for (int i = 0; i < N; i++) begin
      press_cnt[i] = 0; release_cnt[i] = 0; short_cnt[i] = 0; long_cnt[i] = 0;
      level_hi[i] = 0; press_first[i] = -1; release_cyc[i] = -1;
      short_cyc[i] = -1; long_cyc[i] = -1;
    end
    all_press_cnt = 0; all_press_cyc = -1; overlap_cnt = 0; rel_mask = '0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (key_press[i]) begin
          if (press_cnt[i] == 0) press_first[i] = cyc;
          press_cnt[i]++;
        end
        if (key_release[i]) begin release_cnt[i]++; release_cyc[i] = cyc; end
        if (key_short[i])   begin short_cnt[i]++;   short_cyc[i] = cyc;   end
        if (key_long[i])    begin long_cnt[i]++;    long_cyc[i] = cyc;    end
        if (key_level[i])   level_hi[i]++;
        if (key_press[i] && key_release[i]) overlap_cnt++;
      end
      if (key_press == 4'hF) begin all_press_cnt++; all_press_cyc = cyc; end
      rel_mask = rel_mask | key_release;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int t0, t1;
  int exp_press2;

  initial begin
    rst_n  = 1'b0;
    key_in = 4'hF;
    clear_mon();
    tick(3);
    check("reset_outputs", int'({key_level, key_press, key_release, key_short, key_long}), 0);
    rst_n = 1'b1;
    tick(5);
    check("idle_level", int'(key_level), 0);

    // Bounce rejection on key 0.
    clear_mon();
    for (int i = 0; i < 16; i++) begin
      key_in[0] = (i % 2 == 1);
      tick(3);
    end
    key_in[0] = 1'b1;
    tick(30);
    check("bounce_press", press_cnt[0], 0);
    check("bounce_release", release_cnt[0], 0);
    check("bounce_level", level_hi[0], 0);

    // Clean short press on key 1.
    clear_mon();
    key_in[1] = 1'b0; t0 = cyc;
    tick(20);
    key_in[1] = 1'b1; t1 = cyc;
    tick(20);
    check("short_press_cnt", press_cnt[1], 1);
    check("short_press_time", press_first[1], t0 + 10);
    check("short_release_time", release_cyc[1], t1 + 10);
    check("short_short_time", short_cyc[1], t1 + 10);
    check("short_short_cnt", short_cnt[1], 1);
    check("short_long_cnt", long_cnt[1], 0);
    check("short_level_end", int'(key_level[1]), 0);

    // Long press on key 2.
    clear_mon();
    key_in[2] = 1'b0; t0 = cyc;
    tick(100);
    key_in[2] = 1'b1; t1 = cyc;
    tick(20);
`ifdef KEY_REPEAT_EN
    exp_press2 = 6;
`else
    exp_press2 = 1;
`endif
    check("long_press_time", press_first[2], t0 + 10);
    check("long_press_cnt", press_cnt[2], exp_press2);
    check("long_long_cnt", long_cnt[2], 1);
    check("long_long_time", long_cyc[2], t0 + 50);
    check("long_release_time", release_cyc[2], t1 + 10);
    check("long_short_cnt", short_cnt[2], 0);

    // Simultaneous keys.
    clear_mon();
    key_in = 4'h0; t0 = cyc;
    tick(20);
    check("simul_all_press_cnt", all_press_cnt, 1);
    check("simul_all_press_time", all_press_cyc, t0 + 10);
    check("simul_level", int'(key_level), 15);
    key_in[0] = 1'b1; t1 = cyc;
    tick(15);
    check("simul_rel_mask", int'(rel_mask), 1);
    check("simul_rel0_time", release_cyc[0], t1 + 10);
    check("simul_short0", short_cnt[0], 1);
    key_in = 4'hF;
    tick(20);
    check("simul_level_end", int'(key_level), 0);
    check("simul_overlap", overlap_cnt, 0);

    // Reset in the middle of a held press.
    clear_mon();
    key_in[0] = 1'b0;
    tick(15);
    check("rst_held_level", int'(key_level[0]), 1);
    rst_n = 1'b0;
    #2;
    check("rst_async_outputs", int'({key_level, key_press, key_release, key_short, key_long}), 0);
    tick(3);
    clear_mon();
    rst_n = 1'b1; t1 = cyc;
    tick(15);
    check("rst_repress_cnt", press_cnt[0], 1);
    check("rst_repress_time", press_first[0], t1 + 10);
    check("rst_no_release", release_cnt[0], 0);
    key_in[0] = 1'b1;
    tick(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
